// File: rtl/qtable_update_engine_if.sv
// Packet, table-read and status bundle for the EER-RL neighbour / known-CH table engine.
// The master drives packets and read indices; the slave (the engine) returns tables, counts and status.
interface qtable_update_engine_if #(
    parameter int WORD_WIDTH  = 16,
    parameter int NEIGH_DEPTH = 8,
    parameter int CH_DEPTH    = 4
);
    localparam int NIW = $clog2(NEIGH_DEPTH);
    localparam int NCW = $clog2(NEIGH_DEPTH + 1);
    localparam int CIW = $clog2(CH_DEPTH);
    localparam int CCW = $clog2(CH_DEPTH + 1);

    logic                  pkt_valid;
    logic                  pkt_ready;
    logic [WORD_WIDTH-1:0] fSourceID;
    logic [WORD_WIDTH-1:0] fSourceHops;
    logic [WORD_WIDTH-1:0] fClusterID;
    logic [WORD_WIDTH-1:0] fEnergyLeft;
    logic [WORD_WIDTH-1:0] fQValue;
    logic [WORD_WIDTH-1:0] fKnownCH;
    logic                  fCHValid;
    logic                  flush;
    logic [NIW-1:0]        rd_idx;
    logic [WORD_WIDTH-1:0] rd_id;
    logic [WORD_WIDTH-1:0] rd_hops;
    logic [WORD_WIDTH-1:0] rd_cid;
    logic [WORD_WIDTH-1:0] rd_energy;
    logic [WORD_WIDTH-1:0] rd_qvalue;
    logic [CIW-1:0]        ch_rd_idx;
    logic [WORD_WIDTH-1:0] ch_rd_id;
    logic [NCW-1:0]        neighborCount;
    logic [CCW-1:0]        knownCHCount;
    logic                  done;
    logic                  st_hit;
    logic                  st_added;
    logic                  st_dropped;
    logic                  st_evicted;
    logic                  st_ch_added;
    logic                  st_ch_dropped;

    modport master (
        output pkt_valid, fSourceID, fSourceHops, fClusterID, fEnergyLeft, fQValue,
               fKnownCH, fCHValid, flush, rd_idx, ch_rd_idx,
        input  pkt_ready, rd_id, rd_hops, rd_cid, rd_energy, rd_qvalue, ch_rd_id,
               neighborCount, knownCHCount, done, st_hit, st_added, st_dropped,
               st_evicted, st_ch_added, st_ch_dropped
    );

    modport slave (
        input  pkt_valid, fSourceID, fSourceHops, fClusterID, fEnergyLeft, fQValue,
               fKnownCH, fCHValid, flush, rd_idx, ch_rd_idx,
        output pkt_ready, rd_id, rd_hops, rd_cid, rd_energy, rd_qvalue, ch_rd_id,
               neighborCount, knownCHCount, done, st_hit, st_added, st_dropped,
               st_evicted, st_ch_added, st_ch_dropped
    );
endinterface

// File: rtl/qtable_update_engine.sv
// Neighbour / known-CH table engine: per packet, search-and-update the neighbour table, then merge the CH ID.
// Define QTU_EVICT_EN to replace the lowest-Q neighbour when the table is full instead of dropping.
//
// state       | meaning
// IDLE        | ready for a packet; flush clears both tables
// SEARCH      | scan neighbour entry i for the latched source ID
// WRITE       | update hit entry, append, or drop/evict on a full table
// CH_SEARCH   | scan known-CH entry j for the latched CH ID
// CH_ADD      | append CH ID or flag it dropped
// DONE        | one-cycle completion strobe
module qtable_update_engine #(
    parameter int WORD_WIDTH  = 16,
    parameter int NEIGH_DEPTH = 8,
    parameter int CH_DEPTH    = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    qtable_update_engine_if.slave   bus
);
    localparam int NIW = $clog2(NEIGH_DEPTH);
    localparam int NCW = $clog2(NEIGH_DEPTH + 1);
    localparam int CIW = $clog2(CH_DEPTH);
    localparam int CCW = $clog2(CH_DEPTH + 1);

    typedef logic [WORD_WIDTH-1:0] word_t;
    typedef enum logic [2:0] {S_IDLE, S_SEARCH, S_WRITE, S_CH_SEARCH, S_CH_ADD, S_DONE} state_t;

    state_t         state_q, state_d;
    logic [NCW-1:0] i_q, count_q;
    logic [CCW-1:0] j_q, chcount_q;
    word_t          src_q, hops_q, cid_q, energy_q, qv_q, kch_q;
    logic           chv_q;
    logic           st_hit_q, st_added_q, st_dropped_q, st_evicted_q, st_ch_added_q, st_ch_dropped_q;

    word_t nb_id_q     [NEIGH_DEPTH];
    word_t nb_hops_q   [NEIGH_DEPTH];
    word_t nb_cid_q    [NEIGH_DEPTH];
    word_t nb_energy_q [NEIGH_DEPTH];
    word_t nb_q_q      [NEIGH_DEPTH];
    word_t ch_id_q     [CH_DEPTH];

`ifdef QTU_EVICT_EN
    logic [NIW-1:0] min_idx_q;
    word_t          min_q;
`endif

    logic [NIW-1:0] i_idx;
    logic [CIW-1:0] j_idx;
    logic           accept, nb_in_range, nb_match, ch_in_range, ch_match, nb_full, ch_full;

    assign i_idx       = i_q[NIW-1:0];
    assign j_idx       = j_q[CIW-1:0];
    assign accept      = (state_q == S_IDLE) && bus.pkt_valid && !bus.flush;
    // In WRITE, i still below count means SEARCH stopped on a hit.
    assign nb_in_range = (i_q < count_q);
    assign nb_match    = nb_in_range && (nb_id_q[i_idx] == src_q);
    assign ch_in_range = (j_q < chcount_q);
    assign ch_match    = ch_in_range && (ch_id_q[j_idx] == kch_q);
    assign nb_full     = (count_q == NCW'(NEIGH_DEPTH));
    assign ch_full     = (chcount_q == CCW'(CH_DEPTH));

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (accept) state_d = S_SEARCH;
            S_SEARCH:    if (nb_match || !nb_in_range) state_d = S_WRITE;
            S_WRITE:     state_d = chv_q ? S_CH_SEARCH : S_DONE;
            S_CH_SEARCH: begin
                if (ch_match)         state_d = S_DONE;
                else if (!ch_in_range) state_d = S_CH_ADD;
            end
            S_CH_ADD:    state_d = S_DONE;
            S_DONE:      state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            i_q <= '0; j_q <= '0; count_q <= '0; chcount_q <= '0;
            src_q <= '0; hops_q <= '0; cid_q <= '0; energy_q <= '0; qv_q <= '0; kch_q <= '0;
            chv_q <= 1'b0;
            st_hit_q <= 1'b0; st_added_q <= 1'b0; st_dropped_q <= 1'b0;
            st_evicted_q <= 1'b0; st_ch_added_q <= 1'b0; st_ch_dropped_q <= 1'b0;
`ifdef QTU_EVICT_EN
            min_idx_q <= '0; min_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (bus.flush) begin
                        count_q   <= '0;
                        chcount_q <= '0;
                    end else if (bus.pkt_valid) begin
                        src_q <= bus.fSourceID;   hops_q <= bus.fSourceHops;
                        cid_q <= bus.fClusterID;  energy_q <= bus.fEnergyLeft;
                        qv_q  <= bus.fQValue;     kch_q <= bus.fKnownCH;
                        chv_q <= bus.fCHValid;
                        i_q <= '0; j_q <= '0;
                        st_hit_q <= 1'b0; st_added_q <= 1'b0; st_dropped_q <= 1'b0;
                        st_evicted_q <= 1'b0; st_ch_added_q <= 1'b0; st_ch_dropped_q <= 1'b0;
                    end
                end
                S_SEARCH: begin
                    if (nb_in_range && !nb_match) i_q <= i_q + NCW'(1);
`ifdef QTU_EVICT_EN
                    // Strict < keeps the lowest index on ties.
                    if (nb_in_range && (i_q == '0 || nb_q_q[i_idx] < min_q)) begin
                        min_idx_q <= i_idx;
                        min_q     <= nb_q_q[i_idx];
                    end
`endif
                end
                S_WRITE: begin
                    if (nb_in_range) begin
                        st_hit_q <= 1'b1;
                    end else if (!nb_full) begin
                        count_q    <= count_q + NCW'(1);
                        st_added_q <= 1'b1;
                    end else begin
`ifdef QTU_EVICT_EN
                        st_evicted_q <= 1'b1;
`else
                        st_dropped_q <= 1'b1;
`endif
                    end
                end
                S_CH_SEARCH: if (ch_in_range && !ch_match) j_q <= j_q + CCW'(1);
                S_CH_ADD: begin
                    if (!ch_full) begin
                        chcount_q     <= chcount_q + CCW'(1);
                        st_ch_added_q <= 1'b1;
                    end else begin
                        st_ch_dropped_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Table storage is not reset; the counts decide what is visible.
    always_ff @(posedge clk) begin
        if (state_q == S_WRITE) begin
            if (nb_in_range) begin
                nb_hops_q[i_idx]   <= hops_q;
                nb_cid_q[i_idx]    <= cid_q;
                nb_energy_q[i_idx] <= energy_q;
                nb_q_q[i_idx]      <= qv_q;
            end else if (!nb_full) begin
                nb_id_q[count_q[NIW-1:0]]     <= src_q;
                nb_hops_q[count_q[NIW-1:0]]   <= hops_q;
                nb_cid_q[count_q[NIW-1:0]]    <= cid_q;
                nb_energy_q[count_q[NIW-1:0]] <= energy_q;
                nb_q_q[count_q[NIW-1:0]]      <= qv_q;
            end
`ifdef QTU_EVICT_EN
            else begin
                nb_id_q[min_idx_q]     <= src_q;
                nb_hops_q[min_idx_q]   <= hops_q;
                nb_cid_q[min_idx_q]    <= cid_q;
                nb_energy_q[min_idx_q] <= energy_q;
                nb_q_q[min_idx_q]      <= qv_q;
            end
`endif
        end
        if (state_q == S_CH_ADD && !ch_full) ch_id_q[chcount_q[CIW-1:0]] <= kch_q;
    end

    logic rd_vis, ch_vis;
    assign rd_vis = (NCW'(bus.rd_idx) < count_q);
    assign ch_vis = (CCW'(bus.ch_rd_idx) < chcount_q);

    assign bus.rd_id         = rd_vis ? nb_id_q[bus.rd_idx]     : '0;
    assign bus.rd_hops       = rd_vis ? nb_hops_q[bus.rd_idx]   : '0;
    assign bus.rd_cid        = rd_vis ? nb_cid_q[bus.rd_idx]    : '0;
    assign bus.rd_energy     = rd_vis ? nb_energy_q[bus.rd_idx] : '0;
    assign bus.rd_qvalue     = rd_vis ? nb_q_q[bus.rd_idx]      : '0;
    assign bus.ch_rd_id      = ch_vis ? ch_id_q[bus.ch_rd_idx]  : '0;
    assign bus.neighborCount = count_q;
    assign bus.knownCHCount  = chcount_q;
    assign bus.pkt_ready     = (state_q == S_IDLE) && !bus.flush;
    assign bus.done          = (state_q == S_DONE);
    assign bus.st_hit        = st_hit_q;
    assign bus.st_added      = st_added_q;
    assign bus.st_dropped    = st_dropped_q;
    assign bus.st_evicted    = st_evicted_q;
    assign bus.st_ch_added   = st_ch_added_q;
    assign bus.st_ch_dropped = st_ch_dropped_q;
endmodule

// File: tb/tb_qtable_update_engine.sv
// Bench for qtable_update_engine: directed scenarios plus random packets against a list-based table model.
// Honours QTU_EVICT_EN the same way as the design.
module tb_qtable_update_engine;
    localparam int W  = 16;
    localparam int ND = 8;
    localparam int CD = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #20 clk = ~clk;

    qtable_update_engine_if #(.WORD_WIDTH(W), .NEIGH_DEPTH(ND), .CH_DEPTH(CD)) bus ();
    qtable_update_engine #(.WORD_WIDTH(W), .NEIGH_DEPTH(ND), .CH_DEPTH(CD)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    // reference tables
    logic [W-1:0] m_id [ND], m_hops [ND], m_cid [ND], m_en [ND], m_q [ND];
    logic [W-1:0] m_ch [CD];
    int m_cnt = 0, m_chcnt = 0;
    int e_lat;
    logic [5:0] e_stat;  // {hit, added, dropped, evicted, ch_added, ch_dropped}

    function automatic logic [5:0] dut_stat();
        return {bus.st_hit, bus.st_added, bus.st_dropped, bus.st_evicted, bus.st_ch_added, bus.st_ch_dropped};
    endfunction

    function void model_pkt(input logic [W-1:0] src, hops, cid, en, q, kch, input logic chv);
        int h, c, mi;
        h = -1; c = -1;
        e_stat = '0;
        for (int k = 0; k < m_cnt; k++) if (h < 0 && m_id[k] == src) h = k;
        if (h >= 0) begin
            e_lat = h + 1;
            m_hops[h] = hops; m_cid[h] = cid; m_en[h] = en; m_q[h] = q;
            e_stat[5] = 1'b1;
        end else begin
            e_lat = m_cnt + 1;
            if (m_cnt < ND) begin
                m_id[m_cnt] = src; m_hops[m_cnt] = hops; m_cid[m_cnt] = cid; m_en[m_cnt] = en; m_q[m_cnt] = q;
                m_cnt++;
                e_stat[4] = 1'b1;
            end else begin
`ifdef QTU_EVICT_EN
                mi = 0;
                for (int k = 1; k < ND; k++) if (m_q[k] < m_q[mi]) mi = k;
                m_id[mi] = src; m_hops[mi] = hops; m_cid[mi] = cid; m_en[mi] = en; m_q[mi] = q;
                e_stat[2] = 1'b1;
`else
                mi = 0;
                e_stat[3] = 1'b1;
`endif
            end
        end
        e_lat += 1;
        if (chv) begin
            for (int k = 0; k < m_chcnt; k++) if (c < 0 && m_ch[k] == kch) c = k;
            if (c >= 0) e_lat += c + 1;
            else begin
                e_lat += m_chcnt + 2;
                if (m_chcnt < CD) begin
                    m_ch[m_chcnt] = kch;
                    m_chcnt++;
                    e_stat[1] = 1'b1;
                end else e_stat[0] = 1'b1;
            end
        end
        e_lat += 1;
    endfunction

    // Drives one packet, waits for done; lat is 100 or more if done never came.
    task automatic send_pkt(input logic [W-1:0] src, hops, cid, en, q, kch, input logic chv, output int lat);
        int g;
        g = 0;
        model_pkt(src, hops, cid, en, q, kch, chv);
        @(negedge clk);
        while (!bus.pkt_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        bus.fSourceID = src; bus.fSourceHops = hops; bus.fClusterID = cid;
        bus.fEnergyLeft = en; bus.fQValue = q; bus.fKnownCH = kch; bus.fCHValid = chv;
        bus.pkt_valid = 1'b1;
        @(posedge clk);
        #1 bus.pkt_valid = 1'b0;
        lat = 1;
        while (bus.done !== 1'b1 && lat < 100) begin
            @(posedge clk);
            #1 lat++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_cnt = 0;
        m_chcnt = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.rd_idx = '0;
        bus.ch_rd_idx = '0;
        #1;
        n_cmp++;
        if ({bus.neighborCount, bus.knownCHCount, bus.done, dut_stat(), bus.pkt_ready} !== {4'd0, 3'd0, 1'b0, 6'd0, 1'b1}) begin
            n_err++;
            $display("FAIL reset_state: got cnt=%0d chcnt=%0d done=%b stat=%b ready=%b, want 0 0 0 000000 1",
                     bus.neighborCount, bus.knownCHCount, bus.done, dut_stat(), bus.pkt_ready);
        end
        n_cmp++;
        if ({bus.rd_id, bus.ch_rd_id} !== 32'd0) begin
            n_err++;
            $display("FAIL reset_reads: got rd_id=%0d ch_rd_id=%0d, want 0 0", bus.rd_id, bus.ch_rd_id);
        end
        @(negedge clk);
        rst = 1'b0;
        m_cnt = 0;
        m_chcnt = 0;
    endtask

    task automatic test_first_packet();
        int lat;
        send_pkt(16'd5, 16'd2, 16'd9, 16'd100, 16'd40, 16'd9, 1'b1, lat);
        n_cmp++;
        if (lat != 5) begin
            n_err++;
            $display("FAIL first_latency: got %0d cycles, want 5", lat);
        end
        n_cmp++;
        if ({dut_stat(), bus.neighborCount, bus.knownCHCount} !== {6'b010010, 4'd1, 3'd1}) begin
            n_err++;
            $display("FAIL first_status: got stat=%b cnt=%0d chcnt=%0d, want 010010 1 1",
                     dut_stat(), bus.neighborCount, bus.knownCHCount);
        end
        bus.rd_idx = 3'd0;
        bus.ch_rd_idx = 2'd0;
        #1;
        n_cmp++;
        if ({bus.rd_id, bus.rd_hops, bus.rd_cid, bus.rd_energy, bus.rd_qvalue, bus.ch_rd_id} !==
            {16'd5, 16'd2, 16'd9, 16'd100, 16'd40, 16'd9}) begin
            n_err++;
            $display("FAIL first_entry: got id=%0d hops=%0d cid=%0d E=%0d Q=%0d ch=%0d, want 5 2 9 100 40 9",
                     bus.rd_id, bus.rd_hops, bus.rd_cid, bus.rd_energy, bus.rd_qvalue, bus.ch_rd_id);
        end
    endtask

    task automatic test_hit();
        int lat;
        send_pkt(16'd5, 16'd3, 16'd9, 16'd80, 16'd55, 16'd9, 1'b1, lat);
        n_cmp++;
        if (lat != 4) begin
            n_err++;
            $display("FAIL hit_latency: got %0d cycles, want 4", lat);
        end
        n_cmp++;
        if ({dut_stat(), bus.neighborCount, bus.knownCHCount} !== {6'b100000, 4'd1, 3'd1}) begin
            n_err++;
            $display("FAIL hit_status: got stat=%b cnt=%0d chcnt=%0d, want 100000 1 1",
                     dut_stat(), bus.neighborCount, bus.knownCHCount);
        end
        bus.rd_idx = 3'd0;
        #1;
        n_cmp++;
        if ({bus.rd_id, bus.rd_energy, bus.rd_qvalue} !== {16'd5, 16'd80, 16'd55}) begin
            n_err++;
            $display("FAIL hit_entry: got id=%0d E=%0d Q=%0d, want 5 80 55", bus.rd_id, bus.rd_energy, bus.rd_qvalue);
        end
    endtask

    task automatic test_fill_full();
        int lat;
        logic found;
        do_reset();
        for (int k = 0; k < ND; k++)
            send_pkt(16'(10 + k), 16'd1, 16'd0, 16'd50, 16'(10 * (k + 1)), 16'd0, 1'b0, lat);
        n_cmp++;
        if (bus.neighborCount !== 4'd8) begin
            n_err++;
            $display("FAIL fill_count: got %0d, want 8", bus.neighborCount);
        end
        send_pkt(16'd99, 16'd4, 16'd7, 16'd60, 16'd70, 16'd0, 1'b0, lat);
        n_cmp++;
        if (lat != 11) begin
            n_err++;
            $display("FAIL full_latency: got %0d cycles, want 11", lat);
        end
        n_cmp++;
`ifdef QTU_EVICT_EN
        if ({dut_stat(), bus.neighborCount} !== {6'b000100, 4'd8}) begin
            n_err++;
            $display("FAIL full_status: got stat=%b cnt=%0d, want 000100 8", dut_stat(), bus.neighborCount);
        end
`else
        if ({dut_stat(), bus.neighborCount} !== {6'b001000, 4'd8}) begin
            n_err++;
            $display("FAIL full_status: got stat=%b cnt=%0d, want 001000 8", dut_stat(), bus.neighborCount);
        end
`endif
        found = 1'b0;
        for (int k = 0; k < ND; k++) begin
            bus.rd_idx = 3'(k);
            #1;
            if (bus.rd_id == 16'd99) found = 1'b1;
            n_cmp++;
            if ({bus.rd_id, bus.rd_hops, bus.rd_cid, bus.rd_energy, bus.rd_qvalue} !==
                {m_id[k], m_hops[k], m_cid[k], m_en[k], m_q[k]}) begin
                n_err++;
                $display("FAIL full_entry[%0d]: got %h, want %h", k,
                         {bus.rd_id, bus.rd_hops, bus.rd_cid, bus.rd_energy, bus.rd_qvalue},
                         {m_id[k], m_hops[k], m_cid[k], m_en[k], m_q[k]});
            end
        end
        n_cmp++;
`ifdef QTU_EVICT_EN
        if (found !== 1'b1) begin
            n_err++;
            $display("FAIL full_id99: present=%b, want 1", found);
        end
`else
        if (found !== 1'b0) begin
            n_err++;
            $display("FAIL full_id99: present=%b, want 0", found);
        end
`endif
    endtask

    task automatic test_ch_overflow();
        int lat;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            send_pkt(16'(1 + k), 16'd1, 16'd0, 16'd10, 16'd5, 16'(100 + k), 1'b1, lat);
            n_cmp++;
            if (lat != e_lat || dut_stat() !== e_stat || bus.knownCHCount !== 3'(m_chcnt)) begin
                n_err++;
                $display("FAIL ch_pkt[%0d]: got lat=%0d stat=%b chcnt=%0d, want %0d %b %0d",
                         k, lat, dut_stat(), bus.knownCHCount, e_lat, e_stat, m_chcnt);
            end
        end
        n_cmp++;
        if ({bus.st_ch_dropped, bus.st_ch_added, bus.knownCHCount} !== {1'b1, 1'b0, 3'd4}) begin
            n_err++;
            $display("FAIL ch_overflow: got dropped=%b added=%b chcnt=%0d, want 1 0 4",
                     bus.st_ch_dropped, bus.st_ch_added, bus.knownCHCount);
        end
    endtask

    task automatic test_flush();
        int lat, g;
        logic saw_done;
        g = 0;
        @(negedge clk);
        while (!bus.pkt_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        bus.fSourceID = 16'd42; bus.fSourceHops = 16'd1; bus.fClusterID = 16'd3;
        bus.fEnergyLeft = 16'd77; bus.fQValue = 16'd12; bus.fKnownCH = 16'd3; bus.fCHValid = 1'b1;
        bus.flush = 1'b1;
        bus.pkt_valid = 1'b1;
        #1;
        n_cmp++;
        if (bus.pkt_ready !== 1'b0) begin
            n_err++;
            $display("FAIL flush_ready: got %b, want 0", bus.pkt_ready);
        end
        @(posedge clk);
        #1;
        saw_done = bus.done;
        n_cmp++;
        if ({bus.neighborCount, bus.knownCHCount, saw_done} !== {4'd0, 3'd0, 1'b0}) begin
            n_err++;
            $display("FAIL flush_clear: got cnt=%0d chcnt=%0d done=%b, want 0 0 0",
                     bus.neighborCount, bus.knownCHCount, saw_done);
        end
        m_cnt = 0;
        m_chcnt = 0;
        model_pkt(16'd42, 16'd1, 16'd3, 16'd77, 16'd12, 16'd3, 1'b1);
        @(negedge clk);
        bus.flush = 1'b0;
        @(posedge clk);
        #1 bus.pkt_valid = 1'b0;
        lat = 1;
        while (bus.done !== 1'b1 && lat < 100) begin
            @(posedge clk);
            #1 lat++;
        end
        n_cmp++;
        if (lat != e_lat || dut_stat() !== e_stat || bus.neighborCount !== 4'd1) begin
            n_err++;
            $display("FAIL flush_then_accept: got lat=%0d stat=%b cnt=%0d, want %0d %b 1",
                     lat, dut_stat(), bus.neighborCount, e_lat, e_stat);
        end
    endtask

    task automatic test_reset_mid_search();
        int lat;
        logic saw_done;
        for (int k = 0; k < 5; k++)
            send_pkt(16'(200 + k), 16'd2, 16'd2, 16'd2, 16'd2, 16'd0, 1'b0, lat);
        @(negedge clk);
        bus.fSourceID = 16'd300; bus.fCHValid = 1'b1; bus.fKnownCH = 16'd8;
        bus.pkt_valid = 1'b1;
        @(posedge clk);
        #1 bus.pkt_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #5 rst = 1'b1;
        #1;
        n_cmp++;
        if ({bus.neighborCount, bus.knownCHCount, bus.done, dut_stat(), bus.rd_id} !== {4'd0, 3'd0, 1'b0, 6'd0, 16'd0}) begin
            n_err++;
            $display("FAIL midrst_clear: got cnt=%0d chcnt=%0d done=%b stat=%b rd_id=%0d, want all 0",
                     bus.neighborCount, bus.knownCHCount, bus.done, dut_stat(), bus.rd_id);
        end
        saw_done = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1 if (bus.done === 1'b1) saw_done = 1'b1;
        end
        @(negedge clk);
        rst = 1'b0;
        m_cnt = 0;
        m_chcnt = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1 if (bus.done === 1'b1) saw_done = 1'b1;
        end
        n_cmp++;
        if (saw_done !== 1'b0) begin
            n_err++;
            $display("FAIL midrst_no_done: done seen=%b, want 0", saw_done);
        end
        send_pkt(16'd301, 16'd6, 16'd6, 16'd6, 16'd6, 16'd8, 1'b1, lat);
        n_cmp++;
        if (lat != 5 || {dut_stat(), bus.neighborCount, bus.knownCHCount} !== {6'b010010, 4'd1, 3'd1}) begin
            n_err++;
            $display("FAIL midrst_next: got lat=%0d stat=%b cnt=%0d chcnt=%0d, want 5 010010 1 1",
                     lat, dut_stat(), bus.neighborCount, bus.knownCHCount);
        end
    endtask

    task automatic test_random();
        int lat;
        logic [W-1:0] src, kch;
        do_reset();
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 11) == 0) begin
                @(negedge clk);
                while (!bus.pkt_ready) @(negedge clk);
                bus.flush = 1'b1;
                @(posedge clk);
                #1 bus.flush = 1'b0;
                m_cnt = 0;
                m_chcnt = 0;
            end
            src = 16'($urandom_range(0, 11));
            kch = 16'($urandom_range(0, 6));
            send_pkt(src, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom_range(0, 20)),
                     kch, 1'($urandom_range(0, 1)), lat);
            n_cmp++;
            if (lat != e_lat || dut_stat() !== e_stat ||
                bus.neighborCount !== 4'(m_cnt) || bus.knownCHCount !== 3'(m_chcnt)) begin
                n_err++;
                $display("FAIL rand_pkt[%0d]: got lat=%0d stat=%b cnt=%0d chcnt=%0d, want %0d %b %0d %0d",
                         n, lat, dut_stat(), bus.neighborCount, bus.knownCHCount, e_lat, e_stat, m_cnt, m_chcnt);
            end
            for (int k = 0; k < ND; k++) begin
                bus.rd_idx = 3'(k);
                #1;
                n_cmp++;
                if (k < m_cnt) begin
                    if ({bus.rd_id, bus.rd_hops, bus.rd_cid, bus.rd_energy, bus.rd_qvalue} !==
                        {m_id[k], m_hops[k], m_cid[k], m_en[k], m_q[k]}) begin
                        n_err++;
                        $display("FAIL rand_entry[%0d]: got %h, want %h", k,
                                 {bus.rd_id, bus.rd_hops, bus.rd_cid, bus.rd_energy, bus.rd_qvalue},
                                 {m_id[k], m_hops[k], m_cid[k], m_en[k], m_q[k]});
                    end
                end else if ({bus.rd_id, bus.rd_hops, bus.rd_cid, bus.rd_energy, bus.rd_qvalue} !== 80'd0) begin
                    n_err++;
                    $display("FAIL rand_hidden[%0d]: got %h, want 0", k,
                             {bus.rd_id, bus.rd_hops, bus.rd_cid, bus.rd_energy, bus.rd_qvalue});
                end
            end
            for (int k = 0; k < CD; k++) begin
                bus.ch_rd_idx = 2'(k);
                #1;
                n_cmp++;
                if (bus.ch_rd_id !== ((k < m_chcnt) ? m_ch[k] : 16'd0)) begin
                    n_err++;
                    $display("FAIL rand_ch[%0d]: got %0d, want %0d", k, bus.ch_rd_id,
                             (k < m_chcnt) ? m_ch[k] : 16'd0);
                end
            end
        end
    endtask

    initial begin
        bus.pkt_valid = 1'b0; bus.flush = 1'b0; bus.fCHValid = 1'b0;
        bus.fSourceID = '0; bus.fSourceHops = '0; bus.fClusterID = '0;
        bus.fEnergyLeft = '0; bus.fQValue = '0; bus.fKnownCH = '0;
        bus.rd_idx = '0; bus.ch_rd_idx = '0;
        test_reset();
        test_first_packet();
        test_hit();
        test_fill_full();
        test_ch_overflow();
        test_flush();
        test_reset_mid_search();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
